// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the pc_sequencer block: FSM encoding, default vectors, PC source select.
// The return-address stack is compiled in only when PC_SEQ_RAS_EN is defined.
package pc_sequencer_pkg;

  localparam logic [1:0] ST_FETCH   = 2'b00;
  localparam logic [1:0] ST_DECODE  = 2'b01;
  localparam logic [1:0] ST_EXEC    = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  localparam logic [7:0] DEF_RESET_VEC = 8'h00;
  localparam logic [7:0] DEF_INT_VEC   = 8'hF0;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_INC,
    SRC_INT,
    SRC_POP,
    SRC_TGT
  } pc_src_e;

  // Sequencing of the three-phase instruction cycle; the unused code recovers to FETCH.
  function automatic logic [1:0] next_state(input logic [1:0] cur,
                                            input logic       imem_ready,
                                            input logic       stall);
    logic [1:0] nxt;
    nxt = cur;
    case (cur)
      ST_FETCH:   nxt = imem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:  nxt = ST_EXEC;
      ST_EXEC:    nxt = stall ? ST_EXEC : ST_FETCH;
      ST_ILLEGAL: nxt = ST_FETCH;
      default:    nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_incr.sv
// Program counter incrementer; the only place pc+1 is formed, wrapping modulo 2^PC_W.
// Used by pc_sequencer regardless of PC_SEQ_RAS_EN.
module pc_incr #(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc_i,
  output logic [PC_W-1:0] pc_o
);

  assign pc_o = pc_i + PC_W'(1);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute program counter sequencer with optional return-address stack.
// Define PC_SEQ_RAS_EN to build the stack; otherwise call acts as jmp and ret as increment.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
  parameter logic [PC_W-1:0] INT_VEC   = PC_W'(DEF_INT_VEC),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            br_taken,
  input  logic            jmp,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] target,
  input  logic            irq,
  output logic [PC_W-1:0] pc,
  output logic            fetch_req,
  output logic            ir_load,
  output logic [1:0]      state,
  output logic            ras_err
);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pop_pc;
  logic            exec_go;
  pc_src_e         pc_src;

  pc_incr #(.PC_W(PC_W)) u_pc_incr (
    .pc_i (pc_q),
    .pc_o (pc_inc)
  );

  assign state_d = next_state(state_q, imem_ready, stall);
  assign exec_go = (state_q == ST_EXEC) && !stall;

`ifdef PC_SEQ_RAS_EN
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int SP_W  = IDX_W + 1;

  logic [PC_W-1:0] ras_mem_q [RAS_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic            ras_err_q, ras_err_d;
  logic            ras_full, ras_empty;
  logic            push_req, pop_req, push_ok, pop_ok;
  logic [IDX_W-1:0] top_idx;

  assign ras_full  = (sp_q == SP_W'(RAS_DEPTH));
  assign ras_empty = (sp_q == '0);
  assign push_ok   = push_req && !ras_full;
  assign pop_ok    = pop_req && !ras_empty;
  assign top_idx   = IDX_W'(sp_q - SP_W'(1));
  assign pop_pc    = ras_mem_q[top_idx];

  always_comb begin
    pc_src   = SRC_HOLD;
    push_req = 1'b0;
    pop_req  = 1'b0;
    if (exec_go) begin
      if (irq) begin
        pc_src   = SRC_INT;
        push_req = 1'b1;
      end else if (ret) begin
        pop_req = 1'b1;
        // An empty stack falls through to sequential execution.
        if (ras_empty) pc_src = SRC_INC;
        else           pc_src = SRC_POP;
      end else if (call) begin
        pc_src   = SRC_TGT;
        push_req = 1'b1;
      end else if (jmp || br_taken) begin
        pc_src = SRC_TGT;
      end else begin
        pc_src = SRC_INC;
      end
    end
  end

  always_comb begin
    sp_d = sp_q;
    if (push_ok)     sp_d = sp_q + SP_W'(1);
    else if (pop_ok) sp_d = sp_q - SP_W'(1);
  end

  assign ras_err_d = ras_err_q | (push_req && ras_full) | (pop_req && ras_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q      <= '0;
      ras_err_q <= 1'b0;
    end else begin
      sp_q      <= sp_d;
      ras_err_q <= ras_err_d;
    end
  end

  // Entries need no reset: the pointer alone defines what is valid, and reset forces FETCH so no push can land.
  always_ff @(posedge clk) begin
    if (push_ok) ras_mem_q[sp_q[IDX_W-1:0]] <= pc_inc;
  end

  assign ras_err = ras_err_q;
`else
  logic unused_ret;
  assign unused_ret = ret;

  always_comb begin
    pc_src = SRC_HOLD;
    if (exec_go) begin
      if (irq)                           pc_src = SRC_INT;
      else if (call || jmp || br_taken)  pc_src = SRC_TGT;
      else                               pc_src = SRC_INC;
    end
  end

  assign pop_pc  = pc_inc;
  assign ras_err = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    case (pc_src)
      SRC_INC:  pc_d = pc_inc;
      SRC_INT:  pc_d = INT_VEC;
      SRC_POP:  pc_d = pop_pc;
      SRC_TGT:  pc_d = target;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc        = pc_q;
  assign state     = state_q;
  assign fetch_req = (state_q == ST_FETCH);
  // Gated by rst_n so no load strobe escapes while reset is held.
  assign ir_load   = fetch_req && imem_ready && rst_n;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 8, program counter width in bits.
REQ-002 Parameter RESET_VEC, default 8'h00, PC value loaded on reset.
REQ-003 Parameter INT_VEC, default 8'hF0, PC value loaded on interrupt entry.
REQ-004 Parameter RAS_DEPTH, default 4, return-address stack entries (power of two, 2..8).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 imem_ready  input  1  instruction memory has valid data for the current fetch.
REQ-009 stall  input  1  hold the sequencer in EXECUTE; no PC update.
REQ-010 br_taken  input  1  conditional branch resolved taken (EXECUTE only).
REQ-011 jmp  input  1  unconditional jump (EXECUTE only).
REQ-012 call  input  1  jump and push the return address (EXECUTE only).
REQ-013 ret  input  1  pop the return address and jump to it (EXECUTE only).
REQ-014 target  input  PC_W  destination for br_taken, jmp and call.
REQ-015 irq  input  1  level interrupt request, sampled in EXECUTE.
REQ-016 pc  output  PC_W  current program counter.
REQ-017 fetch_req  output  1  instruction fetch request.
REQ-018 ir_load  output  1  one-cycle strobe to latch the instruction register.
REQ-019 state  output  2  FSM state: 00 FETCH, 01 DECODE, 10 EXECUTE.
REQ-020 ras_err  output  1  sticky flag: stack overflow or underflow occurred.

Function
REQ-021 The FSM SHALL have states FETCH, DECODE and EXECUTE. Encoding 2'b11 is illegal and SHALL return to FETCH on the next clock.
REQ-022 In FETCH, fetch_req SHALL be 1. The FSM SHALL remain in FETCH while imem_ready=0 and SHALL move to DECODE on the clock where imem_ready=1.
REQ-023 ir_load SHALL be 1 exactly in the FETCH cycle where imem_ready=1, and 0 otherwise.
REQ-024 DECODE SHALL last one cycle and then go to EXECUTE. pc SHALL be unchanged in DECODE.
REQ-025 In EXECUTE with stall=1, the FSM SHALL remain in EXECUTE, with no PC or stack change.
REQ-026 In EXECUTE with stall=0, the FSM SHALL go to FETCH and load pc by this priority:
  - irq: INT_VEC, and push pc+1.
  - ret: popped entry.
  - call: target, and push pc+1.
  - jmp or br_taken: target.
  - otherwise: pc+1.
REQ-027 All pc+1 arithmetic SHALL be modulo 2^PC_W (8'hFF+1 = 8'h00) and SHALL be produced by the incrementer sub-module.
REQ-028 A push with the stack full SHALL discard the push, set ras_err and still redirect pc.
REQ-029 A pop with the stack empty SHALL load pc+1 instead, and SHALL set ras_err.
REQ-030 Redirect inputs SHALL be ignored outside EXECUTE. The instruction latency SHALL be at least 3 cycles (FETCH, DECODE, EXECUTE).

Reset
REQ-031 While rst_n=0, the outputs SHALL be: pc=RESET_VEC, state=FETCH, stack pointer=0 (empty), ras_err=0, ir_load=0. fetch_req SHALL follow the FETCH state and so equal 1.
REQ-032 Reset asserted mid-fetch or mid-execute SHALL abort the instruction with no stack write. The first fetch after release SHALL be from RESET_VEC.

Configuration
REQ-033 Macro PC_SEQ_RAS_EN SHALL compile the return-address stack in.
  - Defined: call, ret and irq push/pop as specified.
  - Undefined: there is no stack; call behaves as jmp, ret behaves as increment, irq loads INT_VEC with no push, and ras_err is tied to 0.

Structure
REQ-034 A shared package SHALL hold the state encoding constants and the RESET_VEC and INT_VEC defaults.
REQ-035 The PC+1 function SHALL be one sub-module, pc_incr (input PC_W, output PC_W), instantiated once.

Verification
REQ-036 Release reset with imem_ready=1 and no redirects -> pc sequence 00,01,02; ir_load pulses every 3 cycles.
REQ-037 Hold imem_ready=0 for 4 cycles in FETCH -> state stays 00, pc stays constant, ir_load=0 until ready.
REQ-038 At pc=8'h10 assert call with target=8'h40; later assert ret -> pc=40, then 11; ras_err=0.
REQ-039 Issue 5 calls with RAS_DEPTH=4 -> ras_err=1 after the 5th. Then issue 5 rets -> returns in LIFO order, and the 5th ret loads pc+1.
REQ-040 Assert irq, br_taken and ret together at pc=8'hFF -> pc=F0 and 8'h00 is pushed. Assert stall for 3 cycles -> pc holds.
REQ-041 Assert rst_n=0 during the DECODE after a call -> pc=00, stack empty, ras_err=0.
